fetch_unit: RTL and testbench

Instruction fetch stage for the DIBU core. Holds the program counter, runs a request/acknowledge handshake to instruction memory, and hands each fetched word to the instruction register as a one-cycle write-enable pulse with data. Redirects on branches and holds the delivered word while the downstream stage stalls.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_pc_counter.sv | 21 ++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default widths for the fetch stage.
package fetch_pkg;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        DELIVER = 2'b10
    } state_t;
endpackage

// File: rtl/fetch_pc_counter.sv
// pc_counter: program counter with branch load, increment and hold.
module pc_counter
    import fetch_pkg::*;
#(
    parameter int                WIDTH    = PC_W,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] nxt
);
    assign nxt = load ? target : inc ? pc + 1'b1 : pc;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= nxt;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, memory request/ack handshake and delivery
// of fetched words to the instruction register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   PC_WIDTH    = PC_W,
    parameter int                   INSTR_WIDTH = INSTR_W,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   branch_valid,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   ir_w_en,
    output logic [INSTR_WIDTH-1:0] ir_d,
    output logic [PC_WIDTH-1:0]    ir_pc,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy
);
    state_t                 state, state_nxt;
    logic                   redirect_pend, accept;
    logic [PC_WIDTH-1:0]    req_addr, pc_nxt;
    logic [INSTR_WIDTH-1:0] buffer;

    pc_counter #(.WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load   (branch_valid),
        .inc    (ir_w_en),
        .target (branch_target),
        .pc     (pc),
        .nxt    (pc_nxt)
    );

    always_comb begin
        state_nxt = state;
        ir_w_en   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: state_nxt = en ? REQ : IDLE;
            REQ: begin
                accept    = mem_ack && !redirect_pend && !branch_valid;
                state_nxt = !mem_ack ? REQ : accept ? DELIVER : en ? REQ : IDLE;
            end
            DELIVER: begin
                ir_w_en   = !stall && !branch_valid;
                state_nxt = (ir_w_en || branch_valid) ? (en ? REQ : IDLE) : DELIVER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req_addr freezes the address of an outstanding request across redirects
    assign mem_req  = state == REQ;
    assign mem_addr = mem_req ? req_addr : pc;
    assign busy     = state != IDLE;
    assign ir_d     = buffer;
    assign ir_pc    = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            redirect_pend <= 1'b0;
            req_addr      <= RESET_PC;
            buffer        <= '0;
        end else begin
            state <= state_nxt;
            if (state == REQ) redirect_pend <= mem_ack ? 1'b0 : (redirect_pend || branch_valid);
            if (accept) buffer <= mem_rdata;
            else if (state == DELIVER && branch_valid) buffer <= '0;
            if (state_nxt == REQ && (state != REQ || mem_ack)) req_addr <= pc_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-programmable
// memory responder returning base + address.
module tb_fetch_unit;
    logic        clk = 0, rst = 0, en = 0, stall = 0, branch_valid = 0;
    logic [7:0]  branch_target = 0;
    logic        mem_req, mem_ack, ir_w_en, busy;
    logic [7:0]  mem_addr, ir_pc, pc;
    logic [15:0] mem_rdata, ir_d;

    int          lat = 0, cnt = 0, cyc = 0, n_del = 0, total = 0, bad = 0;
    logic        force_ack = 0;
    logic [15:0] base = 16'hA000;
    logic [23:0] exp_q[$];
    int          del_t[$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_w_en(ir_w_en), .ir_d(ir_d), .ir_pc(ir_pc), .pc(pc), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_ack   = force_ack || (mem_req && cnt >= lat);
    assign mem_rdata = base + {8'h00, mem_addr};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        cnt <= (!mem_req || mem_ack) ? 0 : cnt + 1;
    end

    // scoreboard: every delivered word must match the oldest expected entry
    always @(negedge clk) begin
        if (rst && ir_w_en) begin
            n_del++;
            del_t.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_delivery got pc=%h data=%h", ir_pc, ir_d);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({ir_pc, ir_d} !== e) begin
                    bad++;
                    $display("FAIL delivery got pc=%h data=%h exp pc=%h data=%h",
                             ir_pc, ir_d, e[23:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 0; en = 0; stall = 0; branch_valid = 0; force_ack = 0; lat = 0; base = 16'hA000;
        exp_q.delete();
        tick; tick;
        rst = 1;
        del_t.delete();
        tick;
    endtask

    task automatic wait_del(input int n, input string nm);
        int k = 0;
        while (n_del < n && k < 40) begin tick; k++; end
        total++;
        if (n_del < n) begin
            bad++;
            $display("FAIL %s timeout deliveries=%0d required=%0d", nm, n_del, n);
        end
    endtask

    task automatic wait_req(input logic [7:0] a, input string nm);
        int k = 0;
        while (!(mem_req && mem_addr === a) && k < 20) begin tick; k++; end
        total++;
        if (!(mem_req && mem_addr === a)) begin
            bad++;
            $display("FAIL %s no request at %h, got req=%b addr=%h", nm, a, mem_req, mem_addr);
        end
    endtask

    task automatic wait_deliver_state(input string nm);
        int k = 0;
        while (!(busy && !mem_req) && k < 20) begin tick; k++; end
        total++;
        if (!(busy && !mem_req)) begin
            bad++;
            $display("FAIL %s never reached deliver busy=%b req=%b", nm, busy, mem_req);
        end
    endtask

    task automatic check_end(input string nm);
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_end got busy=%b pending=%0d exp busy=0 pending=0", nm, busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 0;
        #1;
        total++;
        if ({mem_req, ir_w_en, busy} !== 3'b000 || pc !== 8'h00 || ir_pc !== 8'h00 || ir_d !== 16'h0) begin
            bad++;
            $display("FAIL reset_values got req=%b wen=%b busy=%b pc=%h ir_pc=%h ir_d=%h exp all 0",
                     mem_req, ir_w_en, busy, pc, ir_pc, ir_d);
        end
        tick;
        rst = 1; lat = 5; en = 1;
        tick; tick;
        total++;
        if (mem_req !== 1'b1 || pc !== 8'h00) begin
            bad++;
            $display("FAIL reset_req_raised got req=%b pc=%h exp req=1 pc=00", mem_req, pc);
        end
        #2 rst = 0;
        #1;
        total++;
        if ({mem_req, ir_w_en, busy} !== 3'b000 || pc !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_req got req=%b wen=%b busy=%b pc=%h exp 0 0 0 00",
                     mem_req, ir_w_en, busy, pc);
        end
        en = 0;
        tick;
        rst = 1;
        tick;
        force_ack = 1;
        tick;
        force_ack = 0;
        tick;
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || pc !== 8'h00 || n_del != 0) begin
            bad++;
            $display("FAIL reset_stray_ack got busy=%b req=%b pc=%h deliveries=%0d exp 0 0 00 0",
                     busy, mem_req, pc, n_del);
        end
        lat = 0;
    endtask

    task automatic test_seq;
        int d0;
        do_reset;
        d0 = n_del;
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 16'hA000 + 16'(i)});
        en = 1;
        wait_del(d0 + 3, "seq_three");
        en = 0;
        wait_del(d0 + 4, "seq_en_drop_completes");
        tick; tick;
        for (int i = 1; i < 4; i++) begin
            total++;
            if (del_t.size() < 4 || del_t[i] - del_t[i-1] != 2) begin
                bad++;
                $display("FAIL seq_spacing_%0d got=%0d exp=2", i,
                         del_t.size() < 4 ? -1 : del_t[i] - del_t[i-1]);
            end
        end
        check_end("seq");
    endtask

    task automatic test_stall;
        do_reset;
        base = 16'h1234;
        stall = 1;
        exp_q.push_back({8'h00, 16'h1234});
        en = 1;
        wait_deliver_state("stall");
        en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ir_w_en !== 1'b0 || pc !== 8'h00 || ir_d !== 16'h1234) begin
                bad++;
                $display("FAIL stall_hold_%0d got wen=%b pc=%h ir_d=%h exp 0 00 1234", i, ir_w_en, pc, ir_d);
            end
            tick;
        end
        stall = 0;
        @(negedge clk);
        total++;
        if (ir_w_en !== 1'b1 || ir_d !== 16'h1234 || ir_pc !== 8'h00) begin
            bad++;
            $display("FAIL stall_release got wen=%b ir_d=%h ir_pc=%h exp 1 1234 00", ir_w_en, ir_d, ir_pc);
        end
        tick;
        total++;
        if (pc !== 8'h01) begin
            bad++;
            $display("FAIL stall_pc_advance got=%h exp=01", pc);
        end
        check_end("stall");
    endtask

    task automatic test_branch_req;
        int d0;
        do_reset;
        d0 = n_del;
        lat = 2;
        en = 1;
        wait_req(8'h00, "br_req_first");
        branch_valid = 1; branch_target = 8'h40;
        tick;
        branch_valid = 0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || pc !== 8'h40) begin
            bad++;
            $display("FAIL br_req_latched got req=%b addr=%h pc=%h exp 1 00 40", mem_req, mem_addr, pc);
        end
        exp_q.push_back({8'h40, 16'hA040});
        wait_req(8'h40, "br_req_target");
        en = 0;
        wait_del(d0 + 1, "br_req_deliver");
        tick; tick;
        check_end("br_req");
    endtask

    task automatic test_branch_deliver;
        int d0;
        do_reset;
        d0 = n_del;
        stall = 1;
        en = 1;
        wait_deliver_state("br_del");
        branch_valid = 1; branch_target = 8'h10;
        @(negedge clk);
        total++;
        if (ir_w_en !== 1'b0) begin
            bad++;
            $display("FAIL br_del_no_wen got=%b exp=0", ir_w_en);
        end
        tick;
        branch_valid = 0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h10 || pc !== 8'h10) begin
            bad++;
            $display("FAIL br_del_redirect got req=%b addr=%h pc=%h exp 1 10 10", mem_req, mem_addr, pc);
        end
        exp_q.push_back({8'h10, 16'hA010});
        stall = 0;
        en = 0;
        wait_del(d0 + 1, "br_del_deliver");
        tick; tick;
        check_end("br_del");
    endtask

    task automatic test_wrap;
        int d0;
        do_reset;
        d0 = n_del;
        branch_valid = 1; branch_target = 8'hFF;
        tick;
        branch_valid = 0;
        total++;
        if (pc !== 8'hFF || busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_idle_branch got pc=%h busy=%b exp FF 0", pc, busy);
        end
        exp_q.push_back({8'hFF, 16'hA0FF});
        exp_q.push_back({8'h00, 16'hA000});
        en = 1;
        wait_del(d0 + 1, "wrap_first");
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL wrap_addr got req=%b addr=%h exp 1 00", mem_req, mem_addr);
        end
        en = 0;
        wait_del(d0 + 2, "wrap_second");
        tick;
        total++;
        if (pc !== 8'h01) begin
            bad++;
            $display("FAIL wrap_pc got=%h exp=01", pc);
        end
        check_end("wrap");
    endtask

    initial begin
        test_reset;
        test_seq;
        test_stall;
        test_branch_req;
        test_branch_deliver;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
